// File: rtl/fifo_bank_pkg.sv
// Shared sizing defaults for the FIFO bank and the round-robin scheduler blocks.
// Queue-id and count widths are derived here so every block agrees on them.
package fifo_bank_pkg;

   localparam int QUEUE_QUANTITY_DEF     = 4;
   localparam int DATA_BITS_DEF          = 8;
   localparam int BUF_WIDTH_DEF          = 3;
   localparam int ALMOST_FULL_THRESH_DEF = 6;

   // Width of a queue index; a bank always holds at least two queues.
   function automatic int qid_width(input int queues);
      return (queues > 1) ? $clog2(queues) : 1;
   endfunction

   // Occupancy counter must be able to hold the full depth value.
   function automatic int cnt_width(input int buf_width);
      return buf_width + 1;
   endfunction

endpackage

// File: rtl/fifo_queue.sv
// One circular-buffer queue: storage, pointers, occupancy count and status flags.
// Optional almost-full flag is built when FIFO_BANK_ALMOST_FULL_EN is defined.
module fifo_queue
   import fifo_bank_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int BUF_WIDTH = BUF_WIDTH_DEF
`ifdef FIFO_BANK_ALMOST_FULL_EN
   ,
   parameter int ALMOST_FULL_THRESH = ALMOST_FULL_THRESH_DEF
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DATA_BITS-1:0] wr_data,
   output logic [DATA_BITS-1:0] rd_word,
   output logic                 empty,
   output logic                 full
`ifdef FIFO_BANK_ALMOST_FULL_EN
   ,
   output logic                 almost_full
`endif
);

   localparam int DEPTH = 1 << BUF_WIDTH;
   localparam int CNT_W = cnt_width(BUF_WIDTH);

   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [BUF_WIDTH-1:0] wr_ptr;
   logic [BUF_WIDTH-1:0] rd_ptr;
   logic [CNT_W-1:0]     count;

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr] <= wr_data;
   end

   assign rd_word = mem[rd_ptr];
   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));

`ifdef FIFO_BANK_ALMOST_FULL_EN
   assign almost_full = (count >= CNT_W'(ALMOST_FULL_THRESH));
`endif

endmodule

// File: rtl/fifo_bank.sv
// Bank of independent FIFO queues: push decode by destination, scheduler-driven pop,
// registered read port. Define FIFO_BANK_ALMOST_FULL_EN to add the almost_full output.
module fifo_bank
   import fifo_bank_pkg::*;
#(
   parameter int QUEUE_QUANTITY = QUEUE_QUANTITY_DEF,
   parameter int DATA_BITS      = DATA_BITS_DEF,
   parameter int BUF_WIDTH      = BUF_WIDTH_DEF
`ifdef FIFO_BANK_ALMOST_FULL_EN
   ,
   parameter int ALMOST_FULL_THRESH = ALMOST_FULL_THRESH_DEF
`endif
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               enb,
   input  logic                               wr_valid,
   input  logic [$clog2(QUEUE_QUANTITY)-1:0]  wr_dest,
   input  logic [DATA_BITS-1:0]               wr_data,
   output logic                               wr_ready,
   input  logic [$clog2(QUEUE_QUANTITY)-1:0]  selector,
   input  logic                               selector_enb,
   output logic [QUEUE_QUANTITY-1:0]          buf_empty,
   output logic [QUEUE_QUANTITY-1:0]          buf_full,
   output logic                               rd_valid,
   output logic [DATA_BITS-1:0]               rd_data,
   output logic [$clog2(QUEUE_QUANTITY)-1:0]  rd_queue
`ifdef FIFO_BANK_ALMOST_FULL_EN
   ,
   output logic [QUEUE_QUANTITY-1:0]          almost_full
`endif
);

   localparam int QID_W = $clog2(QUEUE_QUANTITY);

   logic                      push_ok;
   logic                      pop_ok;
   logic [QUEUE_QUANTITY-1:0] push_q;
   logic [QUEUE_QUANTITY-1:0] pop_q;
   logic [DATA_BITS-1:0]      q_word [QUEUE_QUANTITY];

   logic                      vld_p1;
   logic [DATA_BITS-1:0]      rd_data_p1;
   logic [QID_W-1:0]          rd_queue_p1;

   // Flags come from registered counts, so a full queue refuses a push even when
   // popped in the same cycle, and an empty queue ignores a pop even when pushed.
   assign wr_ready = enb & ~buf_full[wr_dest];
   assign push_ok  = enb & wr_valid & ~buf_full[wr_dest];
   assign pop_ok   = enb & selector_enb & ~buf_empty[selector];

   for (genvar i = 0; i < QUEUE_QUANTITY; i++) begin : g_queue
      assign push_q[i] = push_ok & (wr_dest  == QID_W'(i));
      assign pop_q[i]  = pop_ok  & (selector == QID_W'(i));

      fifo_queue #(
         .DATA_BITS          (DATA_BITS),
         .BUF_WIDTH          (BUF_WIDTH)
`ifdef FIFO_BANK_ALMOST_FULL_EN
         ,
         .ALMOST_FULL_THRESH (ALMOST_FULL_THRESH)
`endif
      ) u_queue (
         .clk         (clk),
         .rst         (rst),
         .push        (push_q[i]),
         .pop         (pop_q[i]),
         .wr_data     (wr_data),
         .rd_word     (q_word[i]),
         .empty       (buf_empty[i]),
         .full        (buf_full[i])
`ifdef FIFO_BANK_ALMOST_FULL_EN
         ,
         .almost_full (almost_full[i])
`endif
      );
   end

   // Stage p0 -> p1: registered read port, data and source queue hold when idle
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1      <= 1'b0;
         rd_data_p1  <= '0;
         rd_queue_p1 <= '0;
      end else begin
         vld_p1 <= pop_ok;
         if (pop_ok) begin
            rd_data_p1  <= q_word[selector];
            rd_queue_p1 <= selector;
         end
      end
   end

   assign rd_valid = vld_p1;
   assign rd_data  = rd_data_p1;
   assign rd_queue = rd_queue_p1;

endmodule

// File: tb/tb_fifo_bank.sv
// Directed self-checking bench for fifo_bank (default parameters).
// Almost-full checks are compiled in when FIFO_BANK_ALMOST_FULL_EN is defined.
module tb_fifo_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic       enb;
   logic       wr_valid;
   logic [1:0] wr_dest;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic [1:0] selector;
   logic       selector_enb;
   logic [3:0] buf_empty;
   logic [3:0] buf_full;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic [1:0] rd_queue;
`ifdef FIFO_BANK_ALMOST_FULL_EN
   logic [3:0] almost_full;
`endif

   int checks = 0;
   int errors = 0;

   fifo_bank dut (
      .clk          (clk),
      .rst          (rst),
      .enb          (enb),
      .wr_valid     (wr_valid),
      .wr_dest      (wr_dest),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .selector     (selector),
      .selector_enb (selector_enb),
      .buf_empty    (buf_empty),
      .buf_full     (buf_full),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .rd_queue     (rd_queue)
`ifdef FIFO_BANK_ALMOST_FULL_EN
      ,
      .almost_full  (almost_full)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [1:0] dest, input logic [7:0] data);
      wr_valid = 1'b1;
      wr_dest  = dest;
      wr_data  = data;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic pop_check(input logic [1:0] q, input logic [7:0] exp);
      selector     = q;
      selector_enb = 1'b1;
      tick();
      selector_enb = 1'b0;
      chk("pop_valid", 32'(rd_valid), 32'd1);
      chk("pop_data",  32'(rd_data),  32'(exp));
      chk("pop_queue", 32'(rd_queue), 32'(q));
   endtask

   initial begin
      rst = 1'b1; enb = 1'b1; wr_valid = 1'b0; wr_dest = 2'd0; wr_data = 8'h00;
      selector = 2'd0; selector_enb = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_empty",    32'(buf_empty), 32'hF);
      chk("rst_full",     32'(buf_full),  32'h0);
      chk("rst_rd_valid", 32'(rd_valid),  32'd0);
      chk("rst_rd_data",  32'(rd_data),   32'h00);
      chk("rst_rd_queue", 32'(rd_queue),  32'd0);
      chk("rst_wr_ready", 32'(wr_ready),  32'd1);
`ifdef FIFO_BANK_ALMOST_FULL_EN
      chk("rst_afull",    32'(almost_full), 32'h0);
`endif

      // Two words through queue 2
      push_word(2'd2, 8'hA1);
      chk("q2_empty_clr", 32'(buf_empty), 32'b1011);
      push_word(2'd2, 8'hA2);
      pop_check(2'd2, 8'hA1);
      pop_check(2'd2, 8'hA2);
      chk("q2_empty_set", 32'(buf_empty), 32'hF);
      tick();
      chk("idle_valid", 32'(rd_valid), 32'd0);
      chk("idle_hold",  32'(rd_data),  32'hA2);

      // Offset queue 0 pointers so the later fill wraps
      push_word(2'd0, 8'h01);
      push_word(2'd0, 8'h02);
      push_word(2'd0, 8'h03);
      pop_check(2'd0, 8'h01);
      pop_check(2'd0, 8'h02);
      pop_check(2'd0, 8'h03);
      for (int i = 0; i < 8; i++) push_word(2'd0, 8'(8'h10 + i));
      chk("q0_full",  32'(buf_full),  32'b0001);
      chk("q0_empty", 32'(buf_empty), 32'b1110);
      wr_dest = 2'd0;
      #1;
      chk("q0_wr_ready", 32'(wr_ready), 32'd0);
      wr_dest = 2'd1;
      #1;
      chk("q1_wr_ready", 32'(wr_ready), 32'd1);

      // Push to full queue 0 while popping it: push refused, pop performed
      selector = 2'd0; selector_enb = 1'b1;
      wr_valid = 1'b1; wr_dest = 2'd0; wr_data = 8'hEE;
      tick();
      wr_valid = 1'b0;
      chk("drain0_valid", 32'(rd_valid), 32'd1);
      chk("drain0_data",  32'(rd_data),  32'h10);
      chk("drain0_full",  32'(buf_full), 32'h0);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("drain_valid", 32'(rd_valid), 32'd1);
         chk("drain_data",  32'(rd_data),  32'(8'h10 + i));
      end
      tick();
      selector_enb = 1'b0;
      chk("drain_end_valid", 32'(rd_valid),  32'd0);
      chk("drain_end_hold",  32'(rd_data),   32'h17);
      chk("drain_end_empty", 32'(buf_empty), 32'hF);

      // Queue 1 with 3 words: simultaneous push and pop
      push_word(2'd1, 8'h31);
      push_word(2'd1, 8'h32);
      push_word(2'd1, 8'h33);
      wr_valid = 1'b1; wr_dest = 2'd1; wr_data = 8'h55;
      selector = 2'd1; selector_enb = 1'b1;
      tick();
      wr_valid = 1'b0; selector_enb = 1'b0;
      chk("pp_data",  32'(rd_data),   32'h31);
      chk("pp_empty", 32'(buf_empty), 32'b1101);
      pop_check(2'd1, 8'h32);
      pop_check(2'd1, 8'h33);
      pop_check(2'd1, 8'h55);
      chk("q1_drained", 32'(buf_empty), 32'hF);

      // Push to empty queue 3 with a pop of it: pop ignored
      wr_valid = 1'b1; wr_dest = 2'd3; wr_data = 8'h77;
      selector = 2'd3; selector_enb = 1'b1;
      tick();
      wr_valid = 1'b0; selector_enb = 1'b0;
      chk("pe_valid", 32'(rd_valid),  32'd0);
      chk("pe_empty", 32'(buf_empty), 32'b0111);
      pop_check(2'd3, 8'h77);

      // Pop of empty queue 3
      selector = 2'd3; selector_enb = 1'b1;
      tick();
      selector_enb = 1'b0;
      chk("empty_pop_valid", 32'(rd_valid), 32'd0);
      chk("empty_pop_data",  32'(rd_data),  32'h77);
      chk("empty_pop_queue", 32'(rd_queue), 32'd3);

      // enb low freezes everything
      push_word(2'd2, 8'h44);
      enb = 1'b0;
      wr_valid = 1'b1; wr_dest = 2'd2; wr_data = 8'h99;
      selector = 2'd2; selector_enb = 1'b1;
      #1;
      chk("enb0_wr_ready", 32'(wr_ready), 32'd0);
      tick();
      chk("enb0_valid", 32'(rd_valid),  32'd0);
      chk("enb0_empty", 32'(buf_empty), 32'b1011);
      chk("enb0_hold",  32'(rd_data),   32'h77);
      wr_valid = 1'b0; selector_enb = 1'b0; enb = 1'b1;
      pop_check(2'd2, 8'h44);
      chk("enb_end_empty", 32'(buf_empty), 32'hF);

      // Fill queue 1 to the almost-full level, then reset mid-fill
      for (int i = 0; i < 5; i++) push_word(2'd1, 8'(8'hC0 + i));
`ifdef FIFO_BANK_ALMOST_FULL_EN
      chk("afull_5", 32'(almost_full), 32'h0);
`endif
      push_word(2'd1, 8'hC5);
`ifdef FIFO_BANK_ALMOST_FULL_EN
      chk("afull_6", 32'(almost_full), 32'b0010);
`endif
      chk("fill6_empty", 32'(buf_empty), 32'b1101);
      rst = 1'b1;
      wr_valid = 1'b1; wr_dest = 2'd1; wr_data = 8'hAA;
      tick();
      rst = 1'b0; wr_valid = 1'b0;
      chk("mrst_empty",    32'(buf_empty), 32'hF);
      chk("mrst_full",     32'(buf_full),  32'h0);
      chk("mrst_rd_valid", 32'(rd_valid),  32'd0);
      chk("mrst_rd_data",  32'(rd_data),   32'h00);
      chk("mrst_rd_queue", 32'(rd_queue),  32'd0);
`ifdef FIFO_BANK_ALMOST_FULL_EN
      chk("mrst_afull",    32'(almost_full), 32'h0);
`endif
      selector = 2'd1; selector_enb = 1'b1;
      tick();
      selector_enb = 1'b0;
      chk("mrst_pop_valid", 32'(rd_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
